// File: rtl/ps2_host_tx_if.sv
// Command handshake and transaction result bundle between a command source and ps2_host_tx.
// The master side offers a byte with valid/ready and observes busy, done and status.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic [1:0] status;

   modport master (output tx_data, tx_valid, input tx_ready, busy, done, status);
   modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, status);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte sender driving open-drain clk/data enables; done pulses once per transaction.
// Accepts one command only in IDLE (tx_ready); device edges are seen 2 sync + FILTER_CYCLES cycles late.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES      = 10000,
   parameter int REQ_TIMEOUT_CYCLES  = 1500000,
   parameter int XFER_TIMEOUT_CYCLES = 200000,
   parameter int FILTER_CYCLES       = 8
) (
   input  logic           clk,
   input  logic           rst,
   ps2_host_tx_if.slave   tx,
   input  logic           ps2_clk_in,
   input  logic           ps2_data_in,
   output logic           ps2_clk_oe,
   output logic           ps2_data_oe
);
   localparam int MAX_A   = (INHIBIT_CYCLES > REQ_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : REQ_TIMEOUT_CYCLES;
   localparam int CNT_MAX = (MAX_A > XFER_TIMEOUT_CYCLES) ? MAX_A : XFER_TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int FW      = $clog2(FILTER_CYCLES + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_REQ       = 3'd2;
   localparam logic [2:0] S_SHIFT     = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;
   localparam logic [2:0] S_FIN       = 3'd5;

   // Index 0 is ps2_clk, index 1 is ps2_data.
   logic [1:0]    sync1, sync2, filt;
   logic [FW-1:0] fcnt [2];
   logic          clk_prev;
   logic          fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= 2'b11;
         sync2    <= 2'b11;
         filt     <= 2'b11;
         fcnt[0]  <= '0;
         fcnt[1]  <= '0;
         clk_prev <= 1'b1;
      end else begin
         sync1    <= {ps2_data_in, ps2_clk_in};
         sync2    <= sync1;
         clk_prev <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER_CYCLES - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign fall = clk_prev & ~filt[0];

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [8:0]    sh;
   logic [3:0]    edges;
   logic          nack;
   logic [1:0]    status_q;
   logic          fin;
   logic [1:0]    fin_st;

   // A qualifying edge always takes precedence over a timeout expiring in the same cycle.
   always_comb begin
      fin    = 1'b0;
      fin_st = 2'b00;
      case (state)
         S_REQ: if (!fall && cnt >= CW'(REQ_TIMEOUT_CYCLES - 1)) begin
            fin    = 1'b1;
            fin_st = 2'b01;
         end
         S_SHIFT: if (!fall && cnt >= CW'(XFER_TIMEOUT_CYCLES - 1)) begin
            fin    = 1'b1;
            fin_st = 2'b10;
         end
         S_WAIT_IDLE: if (filt[0] && filt[1]) begin
            fin    = 1'b1;
            fin_st = {nack, nack};
         end else if (cnt >= CW'(XFER_TIMEOUT_CYCLES - 1)) begin
            fin    = 1'b1;
            fin_st = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         sh          <= '0;
         edges       <= '0;
         nack        <= 1'b0;
         status_q    <= 2'b00;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (tx.tx_valid) begin
               sh          <= {~^tx.tx_data, tx.tx_data};
               cnt         <= '0;
               edges       <= '0;
               nack        <= 1'b0;
               ps2_clk_oe  <= 1'b1;
               ps2_data_oe <= (INHIBIT_CYCLES == 1);
               state       <= S_INHIBIT;
            end
            S_INHIBIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(INHIBIT_CYCLES - 2))
                  ps2_data_oe <= 1'b1;
               if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b1;
                  cnt         <= '0;
                  state       <= S_REQ;
               end
            end
            S_REQ: if (fall) begin
               ps2_data_oe <= ~sh[0];
               sh          <= sh >> 1;
               edges       <= 4'd1;
               cnt         <= '0;
               state       <= S_SHIFT;
            end else begin
               cnt <= cnt + 1'b1;
            end
            S_SHIFT: begin
               cnt <= cnt + 1'b1;
               if (fall) begin
                  edges <= edges + 1'b1;
                  // edges holds the count before this edge: 1..8 -> data bits 1..7 and parity
                  if (edges < 4'd9) begin
                     ps2_data_oe <= ~sh[0];
                     sh          <= sh >> 1;
                  end else if (edges == 4'd9) begin
                     ps2_data_oe <= 1'b0;
                  end else begin
                     nack  <= filt[1];
                     state <= S_WAIT_IDLE;
                  end
               end
            end
            S_WAIT_IDLE: cnt <= cnt + 1'b1;
            S_FIN:       state <= S_IDLE;
            default:     state <= S_IDLE;
         endcase
         if (fin) begin
            state       <= S_FIN;
            status_q    <= fin_st;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
         end
      end
   end

   assign tx.tx_ready = (state == S_IDLE);
   assign tx.busy     = (state == S_INHIBIT) || (state == S_REQ) ||
                        (state == S_SHIFT) || (state == S_WAIT_IDLE);
   assign tx.done     = (state == S_FIN);
   assign tx.status   = status_q;
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the voltmeter design. It sends one command byte at a time to the mouse: 0xF4 (enable data reporting), 0xFF (reset) or a sample-rate command. It runs in the 100 MHz domain alongside the mouse receive path. It drives the shared ps2_clk/ps2_data lines open-drain through drive-low enables; the top level instantiates the tri-state pads. While `busy` is high, the top level holds the mouse receiver in reset or ignores its output.

## Interface
- `INHIBIT_CYCLES`, 10000: cycles ps2_clk is held low before the request (100 µs at 100 MHz).
- `REQ_TIMEOUT_CYCLES`, 1500000: maximum wait from clock release to the first device falling edge (15 ms).
- `XFER_TIMEOUT_CYCLES`, 200000: maximum time from the first device falling edge to bus idle after ACK (2 ms).
- `FILTER_CYCLES`, 8: consecutive identical synchronized samples required before a filtered line level changes.

- `clk` in 1: 100 MHz clock. All logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: command byte, captured on handshake.
- `tx_valid` in 1: a command is offered.
- `tx_ready` out 1: high only in IDLE. A transfer starts when `tx_valid && tx_ready` is high at a clock edge.
- `ps2_clk_in` in 1: raw ps2_clk pad input (asynchronous).
- `ps2_data_in` in 1: raw ps2_data pad input (asynchronous).
- `ps2_clk_oe` out 1: 1 = drive ps2_clk low, 0 = release.
- `ps2_data_oe` out 1: 1 = drive ps2_data low, 0 = release.
- `busy` out 1: high from handshake until `done`.
- `done` out 1: single-cycle pulse at the end of every transaction, whether it succeeded or failed.
- `status` out 2: result, valid from `done` and held until the next `done`. 00 = ACK, 01 = no device response, 10 = frame timeout, 11 = NACK.

## Operation
- **Reset values:** `tx_ready`=1, `busy`=0, `done`=0, `status`=00, both `oe`=0, FSM in IDLE.
- **Input conditioning:** each pad input passes through a 2-flop synchronizer and then the `FILTER_CYCLES` stability filter. A falling edge is a filtered-clock transition from 1 to 0. Filtered levels reset to 1.
- **IDLE:** lines released. On handshake, capture `tx_data`, compute odd parity (`~^tx_data`), go to INHIBIT.
- **INHIBIT:** `ps2_clk_oe`=1 for `INHIBIT_CYCLES` cycles. In the last cycle `ps2_data_oe` also goes to 1. Go to REQ.
- **REQ:** `ps2_clk_oe`=0, `ps2_data_oe`=1 (start bit). Wait for a falling edge.
  - If no edge arrives within `REQ_TIMEOUT_CYCLES`, finish with status 01.
- **SHIFT:** on falling edges 1–8, set `ps2_data_oe` = ~bit, sending data LSB first. On edge 9, set `ps2_data_oe` = ~parity. On edge 10, set `ps2_data_oe`=0 (stop bit, line released).
- **ACK:** on edge 11, sample filtered data. 0 = ACK, 1 = NACK (status 11). Go to WAIT_IDLE.
- **WAIT_IDLE:** wait until filtered clock and filtered data are both 1, then finish with status 00 (or 11 for NACK).
- **Frame timeout:** counted from edge 1 through WAIT_IDLE. If `XFER_TIMEOUT_CYCLES` is exceeded, finish with status 10.
- **Finish:**
  - Both `oe` are 0, `done`=1 for one cycle, `status` updated, `busy`=0.
  - Return to IDLE; `tx_ready`=1 on the following cycle.
- `tx_valid` while busy is ignored. `tx_data` changes after capture have no effect.
- A device edge seen in IDLE or INHIBIT is ignored and does not advance the bit counter.

## Timing
- Handshake edge T: `busy`=1, `tx_ready`=0, `ps2_clk_oe`=1 at T+1.
- `ps2_data_oe`=1 at T+`INHIBIT_CYCLES`. `ps2_clk_oe`=0 at T+`INHIBIT_CYCLES`+1.
- Edge detection latency: 2 synchronizer cycles + `FILTER_CYCLES` cycles from a pad transition.
- Each data update lands 1 cycle after the filtered falling edge, well inside the device's clock-low half-period (≥30 µs).
- The timeout counter is checked every cycle. A timeout asserts `done` in the cycle after the count expires.
- **Reset mid-transfer:** `rst`=0 releases both lines and clears the FSM asynchronously, with no `done` pulse.
- **Simultaneous events:** if a timeout expires in the same cycle as a qualifying edge, the edge wins.

## Test plan
1. **Normal transfer, ACK.** Send 0xF4 with a device model that ACKs.
   - Clock held low for exactly 10000 cycles.
   - Bits sampled on device rising edges are 0,0,1,0,1,1,1,1, then parity 0, then stop 1.
   - ACK sampled; `done` pulses with `status`=00. `tx_ready` returns to 1.
2. **Parity 1.** Send 0x00: the device model sees eight 0s and parity 1; `status`=00.
3. **NACK.** Device holds data high on the 11th clock: `status`=11, both `oe`=0.
4. **No response.** No device clocks after the request: `done` arrives `REQ_TIMEOUT_CYCLES` (parameter overridden to 500) after clock release, with `status`=01 and lines released.
5. **Frame timeout and mid-transfer reset.**
   - Device stops after 4 clocks: `status`=10.
   - Separate run: assert `rst`=0 during bit 5 → both `oe` go to 0 immediately, with no `done` pulse.
6. **Glitch rejection and busy ignore.**
   - A 3-cycle low glitch on ps2_clk during REQ (`FILTER_CYCLES`=8) does not advance the bit count.
   - `tx_valid` pulsed while busy is ignored, and the original byte is transmitted intact.
